// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg
// Shared definitions for the register-file write-port arbiter.
//   state_t  : arbiter FSM states (A has priority / B is being forced through)
//   SEL_A/B  : mux select encodings for the address/data write muxes
//   REG_ZERO : hard-wired zero register, never actually written
package wb_port_arbiter_pkg;

  typedef enum logic {
    ST_PRIO_A  = 1'b0,
    ST_FORCE_B = 1'b1
  } state_t;

  localparam logic       SEL_A    = 1'b0;
  localparam logic       SEL_B    = 1'b1;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_port_arbiter_mux.sv
// Mux5Bit2To1
// Plain 5-bit 2:1 multiplexer used on the register-file write-address path.
//   in0 : selected when sel = 0
//   in1 : selected when sel = 1
//   sel : select
//   y   : selected value
module Mux5Bit2To1 (
  input  logic [4:0] in0,
  input  logic [4:0] in1,
  input  logic       sel,
  output logic [4:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the pipeline WB stage (A)
// and the out-of-band multi-cycle unit (B). A has fixed priority; if B is kept
// waiting for MAX_WAIT cycles it is forced through for one cycle while A stalls.
// The winning write is registered onto wr_* one cycle after the grant.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   a_valid/a_addr/a_data     : pipeline write request
//   a_ready                   : low = A not accepted (stall request)
//   b_valid/b_addr/b_data     : multi-cycle unit result, held until b_ready
//   b_ready                   : B request completes this cycle (combinational)
//   mux_sel                   : 0 = A path, 1 = B path
//   wr_en/wr_addr/wr_data     : registered register-file write
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              mux_sel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  state_t            state, state_next;
  logic [3:0]        wait_cnt, wait_next;
  logic              grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  Mux5Bit2To1 u_addr_mux (
    .in0 (a_addr),
    .in1 (b_addr),
    .sel (mux_sel),
    .y   (sel_addr)
  );

  assign sel_data = (mux_sel == SEL_B) ? b_data : a_data;

  // A same-address B write alongside an A grant is older than A, so it is
  // retired (b_ready) without writing; that is not counted as B waiting.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    a_ready    = 1'b1;
    b_ready    = 1'b0;
    mux_sel    = SEL_A;
    grant      = 1'b0;
    case (state)
      ST_PRIO_A: begin
        if (a_valid) begin
          grant = 1'b1;
          if (b_valid && (a_addr == b_addr)) begin
            b_ready = 1'b1;
          end
        end else if (b_valid) begin
          grant   = 1'b1;
          mux_sel = SEL_B;
          b_ready = 1'b1;
        end
        if (b_valid && !b_ready) begin
          wait_next = wait_cnt + 4'd1;
          if (wait_cnt == 4'(MAX_WAIT - 1)) begin
            state_next = ST_FORCE_B;
          end
        end else begin
          wait_next = 4'd0;
        end
      end
      ST_FORCE_B: begin
        a_ready    = 1'b0;
        mux_sel    = SEL_B;
        b_ready    = b_valid;
        grant      = b_valid;
        wait_next  = 4'd0;
        state_next = ST_PRIO_A;
      end
      default: begin
        state_next = ST_PRIO_A;
        wait_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_PRIO_A;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Writes to the zero register complete normally but never assert wr_en.
  // With no grant the address/data hold so the register-file inputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (grant) begin
      wr_en   <= (sel_addr != ADDR_W'(REG_ZERO));
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Directed and randomized checks of wb_port_arbiter against a cycle-level
// reference model of the arbitration rules (A priority, B forced after
// MAX_WAIT consecutive denied cycles, WAW squash, zero-register suppression).
module tb_wb_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        mux_sel;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int testsRun;
  int testsFailed;

  // reference model state
  int          deniedCycles;
  logic        expWrEn;
  logic [4:0]  expWrAddr;
  logic [31:0] expWrData;
  logic        expBReady;

  // comb outputs observed in the most recent applied cycle
  logic obsAReady;
  logic obsBReady;
  logic obsMuxSel;

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(5), .DATA_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .b_ready (b_ready),
    .mux_sel (mux_sel),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    deniedCycles = 0;
    expWrEn      = 1'b0;
    expWrAddr    = '0;
    expWrData    = '0;
  endtask

  // Drive one cycle of inputs (called just after a falling edge), check the
  // combinational response, then check the registered write after the rising edge.
  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    logic        forced;
    logic        eARdy;
    logic        eSel;
    logic        writeGo;
    logic [4:0]  goAddr;
    logic [31:0] goData;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    forced  = (deniedCycles >= MAX_WAIT);
    writeGo = 1'b0;
    goAddr  = '0;
    goData  = '0;
    if (forced) begin
      eARdy     = 1'b0;
      eSel      = 1'b1;
      expBReady = bv;
      writeGo   = bv;
      goAddr    = ba;
      goData    = bd;
      deniedCycles = 0;
    end else begin
      eARdy = 1'b1;
      if (av) begin
        eSel      = 1'b0;
        expBReady = bv && (aa == ba);
        writeGo   = 1'b1;
        goAddr    = aa;
        goData    = ad;
      end else begin
        eSel      = bv;
        expBReady = bv;
        writeGo   = bv;
        goAddr    = ba;
        goData    = bd;
      end
      if (bv && !expBReady) deniedCycles++;
      else deniedCycles = 0;
    end
    obsAReady = a_ready;
    obsBReady = b_ready;
    obsMuxSel = mux_sel;
    checkOutput("a_ready", {31'd0, a_ready}, {31'd0, eARdy});
    checkOutput("b_ready", {31'd0, b_ready}, {31'd0, expBReady});
    if (writeGo) checkOutput("mux_sel", {31'd0, mux_sel}, {31'd0, eSel});
    if (writeGo) begin
      expWrEn   = (goAddr != 5'd0);
      expWrAddr = goAddr;
      expWrData = goData;
    end else begin
      expWrEn = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("wr_en", {31'd0, wr_en}, {31'd0, expWrEn});
    checkOutput("wr_addr", {27'd0, wr_addr}, {27'd0, expWrAddr});
    checkOutput("wr_data", wr_data, expWrData);
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic        bPend;
    logic [4:0]  bAddrR;
    logic [31:0] bDataR;
    logic        av;
    logic [4:0]  aa;
    int          lowCount;
    int          lowIndex;

    testsRun = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    modelReset();

    // reset state
    @(negedge clk);
    #1;
    checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("rst_a_ready", {31'd0, a_ready}, 32'd1);
    checkOutput("rst_b_ready", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    idleCycle();

    // A only
    applyStimulus(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    checkOutput("a_only_sel", {31'd0, obsMuxSel}, 32'd0);
    checkOutput("a_only_wr_en", {31'd0, wr_en}, 32'd1);
    checkOutput("a_only_wr_addr", {27'd0, wr_addr}, 32'd8);
    checkOutput("a_only_wr_data", wr_data, 32'hDEADBEEF);

    // B only
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd5);
    checkOutput("b_only_b_ready", {31'd0, obsBReady}, 32'd1);
    checkOutput("b_only_wr_addr", {27'd0, wr_addr}, 32'd3);
    checkOutput("b_only_wr_data", wr_data, 32'd5);
    idleCycle();

    // WAW squash: only A's data reaches register 9, B never writes later
    applyStimulus(1'b1, 5'd9, 32'h1111AAAA, 1'b1, 5'd9, 32'h2222BBBB);
    checkOutput("waw_b_ready", {31'd0, obsBReady}, 32'd1);
    checkOutput("waw_wr_data", wr_data, 32'h1111AAAA);
    idleCycle();
    checkOutput("waw_no_b_write", {31'd0, wr_en}, 32'd0);

    // zero register
    applyStimulus(1'b1, 5'd0, 32'h0000CAFE, 1'b0, 5'd0, 32'd0);
    checkOutput("zero_a_ready", {31'd0, obsAReady}, 32'd1);
    checkOutput("zero_wr_en", {31'd0, wr_en}, 32'd0);
    idleCycle();

    // starvation: four A grants, one forced B cycle, then A resumes
    lowCount = 0;
    lowIndex = -1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 5'(i + 10), 32'h100 + 32'(i), (i <= 4), 5'd7, 32'h00BB0007);
      if (!obsAReady) begin
        lowCount++;
        lowIndex = i;
      end
      if (i == 4) begin
        checkOutput("starve_b_wr_addr", {27'd0, wr_addr}, 32'd7);
        checkOutput("starve_b_wr_data", wr_data, 32'h00BB0007);
      end
    end
    checkOutput("starve_low_count", 32'(lowCount), 32'd1);
    checkOutput("starve_low_index", 32'(lowIndex), 32'd4);

    // b_valid dropped during the forced cycle: no write, back to A priority
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'd20, 32'd20, 1'b1, 5'd21, 32'd21);
    applyStimulus(1'b1, 5'd20, 32'd20, 1'b0, 5'd21, 32'd21);
    checkOutput("drop_force_a_ready", {31'd0, obsAReady}, 32'd0);
    checkOutput("drop_force_wr_en", {31'd0, wr_en}, 32'd0);
    applyStimulus(1'b1, 5'd22, 32'd22, 1'b0, 5'd0, 32'd0);
    checkOutput("drop_resume_a_ready", {31'd0, obsAReady}, 32'd1);

    // reset asserted while the forced cycle is pending
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'd24, 32'd24, 1'b1, 5'd25, 32'd25);
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h12; b_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_a_ready", {31'd0, a_ready}, 32'd1);
    checkOutput("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("midrst_wr_addr", {27'd0, wr_addr}, 32'd0);
    checkOutput("midrst_wr_data", wr_data, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_hold_wr_en", {31'd0, wr_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic obeying the B hold-until-ready protocol
    bPend = 1'b0;
    bAddrR = '0;
    bDataR = '0;
    for (int n = 0; n < 400; n++) begin
      if (!bPend && ($urandom % 3 == 0)) begin
        bPend  = 1'b1;
        bAddrR = 5'($urandom);
        bDataR = $urandom;
      end
      av = ($urandom % 4) != 0;
      aa = ($urandom % 8 == 0) ? bAddrR : 5'($urandom);
      applyStimulus(av, aa, $urandom, bPend, bAddrR, bDataR);
      if (expBReady) bPend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
